// File: rtl/entrada_pkg.sv
// Shared types and constants for the keypad MM:SS preset entry block.
// Optional preset normalization is enabled with SEG_NORMALIZA_EN.
package entrada_pkg;

  localparam int unsigned DIGITO_W    = 4;
  localparam int unsigned MAX_DIGITOS = 4;
  localparam int unsigned NUM_W       = $clog2(MAX_DIGITOS + 1);

  localparam logic [DIGITO_W-1:0] BCD_MAX    = DIGITO_W'(9);
  localparam logic [DIGITO_W-1:0] SEG_LIMITE = DIGITO_W'(6);

  typedef logic [1:0] estado_t;
  localparam estado_t OCIOSO = 2'd0;
  localparam estado_t FILTRO = 2'd1;
  localparam estado_t ESPERA = 2'd2;

  typedef struct packed {
    logic [DIGITO_W-1:0] min_dez;
    logic [DIGITO_W-1:0] min_uni;
    logic [DIGITO_W-1:0] seg_dez;
    logic [DIGITO_W-1:0] seg_uni;
  } preset_t;

  function automatic logic bcd_valido(input logic [DIGITO_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

  // New digit enters on the right, the oldest one drops off the left.
  function automatic preset_t desloca(input preset_t p, input logic [DIGITO_W-1:0] d);
    preset_t r;
    r.min_dez = p.min_uni;
    r.min_uni = p.seg_dez;
    r.seg_dez = p.seg_uni;
    r.seg_uni = d;
    return r;
  endfunction

endpackage

// File: rtl/entrada_digitos_normalizador.sv
// Combinational MM:SS BCD normalizer: folds seconds >= 60 into minutes, saturating at 99:59.
// Only compiled when SEG_NORMALIZA_EN is defined.
`ifdef SEG_NORMALIZA_EN
module normalizador_tempo
  import entrada_pkg::*;
(
  input  preset_t entrada,
  output preset_t saida
);

  always_comb begin
    saida = entrada;
    if (entrada.seg_dez >= SEG_LIMITE) begin
      saida.seg_dez = entrada.seg_dez - SEG_LIMITE;
      if (entrada.min_uni < BCD_MAX) begin
        saida.min_uni = entrada.min_uni + DIGITO_W'(1);
      end else if (entrada.min_dez < BCD_MAX) begin
        saida.min_uni = '0;
        saida.min_dez = entrada.min_dez + DIGITO_W'(1);
      end else begin
        saida.min_dez = BCD_MAX;
        saida.min_uni = BCD_MAX;
        saida.seg_dez = SEG_LIMITE - DIGITO_W'(1);
        saida.seg_uni = BCD_MAX;
      end
    end
  end

endmodule
`endif

// File: rtl/entrada_digitos.sv
// Debounced keypad digit entry into an MM:SS preset with a one-cycle load pulse.
// Define SEG_NORMALIZA_EN to normalize seconds >= 60 on the load edge.
module entrada_digitos
  import entrada_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DIGITO_W-1:0] bcd,
  input  logic                tecla,
  input  logic                habilita,
  input  logic                limpar,
  input  logic                iniciar,
  output logic [DIGITO_W-1:0] min_dez,
  output logic [DIGITO_W-1:0] min_uni,
  output logic [DIGITO_W-1:0] seg_dez,
  output logic [DIGITO_W-1:0] seg_uni,
  output logic [NUM_W-1:0]    num_digitos,
  output logic                digito_ok,
  output logic                carregar
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0]  CNT_ALVO = CNT_W'(DEBOUNCE);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  preset_t          preset_q, preset_d, preset_desloc, preset_final;
  logic [NUM_W-1:0] num_q, num_d;
  logic             ok_q, ok_d;
  logic             carregar_q, carregar_d;
  logic             aceita, aceita_valida;

  // Debounce FSM: counts qualified high samples to accept, low samples to release.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    aceita   = 1'b0;
    cnt_inc  = cnt_q + CNT_W'(1);
    case (estado_q)
      OCIOSO: begin
        if (tecla && habilita) begin
          if (CNT_W'(1) == CNT_ALVO) begin
            aceita   = 1'b1;
            estado_d = ESPERA;
            cnt_d    = '0;
          end else begin
            estado_d = FILTRO;
            cnt_d    = CNT_W'(1);
          end
        end
      end
      FILTRO: begin
        if (!tecla || !habilita) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else if (cnt_inc == CNT_ALVO) begin
          aceita   = 1'b1;
          estado_d = ESPERA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ESPERA: begin
        if (tecla) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_ALVO) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
      end
    endcase
    if (limpar) begin
      estado_d = OCIOSO;
      cnt_d    = '0;
      aceita   = 1'b0;
    end
  end

  // Digit datapath: invalid codes and a full preset still consume the keypress.
  always_comb begin
    aceita_valida = aceita && bcd_valido(bcd) && (num_q != NUM_W'(MAX_DIGITOS));
    preset_desloc = aceita_valida ? desloca(preset_q, bcd) : preset_q;
    carregar_d    = iniciar && habilita && (num_q != '0) && !limpar;
    ok_d          = aceita_valida;
    if (limpar) begin
      preset_d = '0;
      num_d    = '0;
    end else begin
      preset_d = preset_final;
      num_d    = num_q + NUM_W'(aceita_valida);
    end
  end

`ifdef SEG_NORMALIZA_EN
  preset_t preset_norm;

  normalizador_tempo u_normalizador (
    .entrada (preset_desloc),
    .saida   (preset_norm)
  );

  assign preset_final = carregar_d ? preset_norm : preset_desloc;
`else
  assign preset_final = preset_desloc;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      cnt_q      <= '0;
      preset_q   <= '0;
      num_q      <= '0;
      ok_q       <= 1'b0;
      carregar_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      preset_q   <= preset_d;
      num_q      <= num_d;
      ok_q       <= ok_d;
      carregar_q <= carregar_d;
    end
  end

  assign min_dez     = preset_q.min_dez;
  assign min_uni     = preset_q.min_uni;
  assign seg_dez     = preset_q.seg_dez;
  assign seg_uni     = preset_q.seg_uni;
  assign num_digitos = num_q;
  assign digito_ok   = ok_q;
  assign carregar    = carregar_q;

endmodule

// File: tb/tb_entrada_digitos.sv
// Randomized and directed bench for entrada_digitos against a value-level reference model.
// Expected normalization follows SEG_NORMALIZA_EN when it is defined for the build.
module tb_entrada_digitos;

  localparam int unsigned DEB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] bcd = 4'd0;
  logic       tecla = 1'b0;
  logic       habilita = 1'b1;
  logic       limpar = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
  logic [2:0] num_digitos;
  logic       digito_ok, carregar;

  int checks = 0;
  int errors = 0;
  int n_ok   = 0;

  // Reference model: preset as a decimal number 0..9999 plus digit count.
  int m_valor = 0;
  int m_num = 0;
  int m_run = 0;
  bit m_armado = 1'b1;
  bit m_ok = 1'b0;
  bit m_carregar = 1'b0;

  entrada_digitos #(.DEBOUNCE(DEB)) dut (
    .clock       (clock),
    .reset       (reset),
    .bcd         (bcd),
    .tecla       (tecla),
    .habilita    (habilita),
    .limpar      (limpar),
    .iniciar     (iniciar),
    .min_dez     (min_dez),
    .min_uni     (min_uni),
    .seg_dez     (seg_dez),
    .seg_uni     (seg_uni),
    .num_digitos (num_digitos),
    .digito_ok   (digito_ok),
    .carregar    (carregar)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input int obs, input int esp);
    checks++;
    if (obs != esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  function automatic int para_hex(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int preset_obs();
    return int'({min_dez, min_uni, seg_dez, seg_uni});
  endfunction

  task automatic zera_modelo();
    m_valor = 0; m_num = 0; m_run = 0; m_armado = 1'b1; m_ok = 1'b0; m_carregar = 1'b0;
  endtask

  task automatic passo_modelo();
    bit aceitou;
    int mm, ss;
    aceitou = 1'b0;
    mm = 0;
    ss = 0;
    if (reset || limpar) begin
      zera_modelo();
    end else begin
      if (m_armado) begin
        if (tecla && habilita) begin
          m_run++;
          if (m_run >= int'(DEB)) begin aceitou = 1'b1; m_armado = 1'b0; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end else if (tecla) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run >= int'(DEB)) begin m_armado = 1'b1; m_run = 0; end
      end
      m_carregar = iniciar && habilita && (m_num > 0);
      m_ok = aceitou && (int'(bcd) <= 9) && (m_num < 4);
      if (m_ok) begin
        m_valor = (m_valor * 10 + int'(bcd)) % 10000;
        m_num++;
      end
`ifdef SEG_NORMALIZA_EN
      if (m_carregar) begin
        mm = m_valor / 100;
        ss = m_valor % 100;
        if (ss >= 60) begin ss -= 60; mm++; end
        if (mm > 99) begin mm = 99; ss = 59; end
        m_valor = mm * 100 + ss;
      end
`endif
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    passo_modelo();
    #1;
    verifica("preset", preset_obs(), para_hex(m_valor));
    verifica("num_digitos", int'(num_digitos), m_num);
    verifica("digito_ok", int'(digito_ok), int'(m_ok));
    verifica("carregar", int'(carregar), int'(m_carregar));
    if (digito_ok) n_ok++;
  endtask

  task automatic pressiona(input int d, input int alto, input int baixo);
    bcd = 4'(d);
    tecla = 1'b1;
    repeat (alto) ciclo();
    tecla = 1'b0;
    repeat (baixo) ciclo();
  endtask

  task automatic limpa();
    limpar = 1'b1;
    ciclo();
    limpar = 1'b0;
  endtask

  initial begin
    int acao;
    // Reset state
    repeat (2) ciclo();
    reset = 1'b0;
    verifica("reset_preset", preset_obs(), 0);
    verifica("reset_num", int'(num_digitos), 0);
    ciclo();

    // Keys 1,2,3,0 -> 12:30
    n_ok = 0;
    pressiona(1, 6, 6); pressiona(2, 6, 6); pressiona(3, 6, 6); pressiona(0, 6, 6);
    verifica("preset_1230", preset_obs(), 'h1230);
    verifica("num_4", int'(num_digitos), 4);
    verifica("pulsos_4", n_ok, 4);

    // Fifth key ignored when full
    n_ok = 0;
    pressiona(7, 6, 6);
    verifica("quinta_tecla", preset_obs(), 'h1230);
    verifica("quinta_pulso", n_ok, 0);

    // Invalid code ignored
    limpa();
    pressiona(12, 6, 6);
    verifica("bcd_invalido", int'(num_digitos), 0);

    // iniciar with no digits
    iniciar = 1'b1; ciclo(); iniciar = 1'b0;
    verifica("iniciar_vazio", int'(carregar), 0);

    // Short pulse, then glitch during release
    pressiona(5, 2, 6);
    verifica("pulso_curto", int'(num_digitos), 0);
    n_ok = 0;
    pressiona(5, 5, 1); pressiona(5, 2, 6);
    verifica("glitch_um_digito", int'(num_digitos), 1);
    verifica("glitch_pulsos", n_ok, 1);

    // 9,0 then iniciar
    limpa();
    pressiona(9, 6, 6); pressiona(0, 6, 6);
    iniciar = 1'b1; ciclo(); iniciar = 1'b0;
    verifica("carregar_90", int'(carregar), 1);
`ifdef SEG_NORMALIZA_EN
    verifica("preset_90", preset_obs(), 'h0130);
`else
    verifica("preset_90", preset_obs(), 'h0090);
`endif
    ciclo();
    verifica("carregar_unico", int'(carregar), 0);
    verifica("num_retido", int'(num_digitos), 2);

    // 9999 then iniciar
    limpa();
    repeat (4) pressiona(9, 6, 6);
    iniciar = 1'b1; ciclo(); iniciar = 1'b0;
`ifdef SEG_NORMALIZA_EN
    verifica("preset_9999", preset_obs(), 'h9959);
`else
    verifica("preset_9999", preset_obs(), 'h9999);
`endif

    // limpar after two digits
    limpa();
    pressiona(4, 6, 6); pressiona(2, 6, 6);
    limpa();
    verifica("limpar_preset", preset_obs(), 0);
    verifica("limpar_num", int'(num_digitos), 0);

    // Reset while filtering
    pressiona(3, 6, 6);
    bcd = 4'd8; tecla = 1'b1;
    ciclo(); ciclo();
    reset = 1'b1; ciclo(); reset = 1'b0;
    verifica("reset_filtro_preset", preset_obs(), 0);
    verifica("reset_filtro_ok", int'(digito_ok), 0);
    tecla = 1'b0;
    repeat (6) ciclo();

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      acao = int'($urandom_range(0, 99));
      if (acao < 70) begin
        bcd = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        habilita = ($urandom_range(0, 9) != 0);
        tecla = 1'b1;
        for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
          iniciar = ($urandom_range(0, 9) == 0);
          ciclo();
        end
        tecla = 1'b0;
        for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
          iniciar = ($urandom_range(0, 9) == 0);
          ciclo();
        end
        iniciar = 1'b0;
        habilita = 1'b1;
      end else if (acao < 80) begin
        iniciar = 1'b1;
        repeat ($urandom_range(1, 2)) ciclo();
        iniciar = 1'b0;
        ciclo();
      end else if (acao < 87) begin
        limpar = 1'b1; tecla = 1'($urandom_range(0, 1));
        ciclo();
        limpar = 1'b0; tecla = 1'b0;
      end else if (acao < 90) begin
        reset = 1'b1; ciclo(); reset = 1'b0;
      end else begin
        habilita = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 4)) ciclo();
        habilita = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/entrada_digitos.md
# entrada_digitos

Accumulates decimal keypad digits into a four-digit MM:SS timer preset. Sits directly downstream of the keypad priority encoder and consumes its 4-bit BCD code plus a key-pressed level. Debounces each keypress, shifts accepted digits in from the right, and hands the preset to the timer core with a one-cycle load pulse on start.

## Interface
- `DEBOUNCE`, default 4: consecutive high samples needed to accept a key, and consecutive low samples needed to register release; must be ≥1.
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `bcd` in 4: digit code from the encoder; meaningful only while `tecla`=1.
- `tecla` in 1: level, 1 while any digit key is pressed.
- `habilita` in 1: 1 when entry is allowed (timer stopped).
- `limpar` in 1: synchronous clear of the entered digits.
- `iniciar` in 1: start request, sampled every cycle.
- `min_dez`, `min_uni`, `seg_dez`, `seg_uni` out 4 each: preset digits, BCD.
- `num_digitos` out 3: digits entered, 0..4.
- `digito_ok` out 1: one-cycle pulse when a digit is shifted in.
- `carregar` out 1: one-cycle pulse; digit outputs are the valid preset in that cycle.

## Operation
- Reset values: all four digits 0, `num_digitos`=0, `digito_ok`=0, `carregar`=0, FSM in OCIOSO, debounce counter 0.
- FSM states: OCIOSO, FILTRO, ESPERA.
  - OCIOSO: `tecla`=1 and `habilita`=1 -> FILTRO with counter=1.
  - FILTRO: `tecla`=0 or `habilita`=0 -> OCIOSO with no shift. When the counter reaches `DEBOUNCE`, the digit is accepted and the FSM moves to ESPERA with counter=0. Otherwise the counter increments.
  - ESPERA: each `tecla`=0 sample increments the counter; a `tecla`=1 sample resets it to 0. At `DEBOUNCE` consecutive lows -> OCIOSO.
- Acceptance shifts digits left: `min_dez`<=`min_uni`, `min_uni`<=`seg_dez`, `seg_dez`<=`seg_uni`, `seg_uni`<=`bcd`. It also increments `num_digitos` and pulses `digito_ok`.
- Acceptance is ignored (no shift, no pulse, FSM still enters ESPERA) in two cases:
  - `bcd` > 9.
  - `num_digitos` = 4.
- `iniciar`=1 with `habilita`=1 and `num_digitos`>0 asserts `carregar` the next cycle. Digits and `num_digitos` are retained.
- `iniciar` is ignored if `num_digitos`=0 or `habilita`=0.
- Priority, highest first: `reset`, `limpar`, acceptance/`iniciar`.
  - `limpar` zeroes the digits and `num_digitos` and forces OCIOSO.
  - A key still held after `limpar` re-enters FILTRO and is accepted again after `DEBOUNCE` samples.
- Simultaneous acceptance and `iniciar`: both take effect. The `carregar` cycle shows the post-shift digits.

## Timing
- The key is first sampled high at edge 0 (OCIOSO -> FILTRO, counter=1). The shift happens at edge `DEBOUNCE`−1. `digito_ok` and the new digits are visible in the following cycle.
- A `tecla` pulse shorter than `DEBOUNCE` samples produces no shift.
- Minimum key-to-key period: 2×`DEBOUNCE` cycles.
- `carregar` latency: 1 cycle after `iniciar` is sampled. It is never asserted for two consecutive cycles unless `iniciar` is held.
- Reset mid-FILTRO or mid-ESPERA: outputs return to reset values on that edge and no pulse is emitted.

## Configuration
- `SEG_NORMALIZA_EN` defined: on the edge that raises `carregar`, the preset is normalized. Seconds ≥ 60 subtract 60 and carry 1 into minutes (BCD arithmetic). If the minutes would then exceed 99, the preset saturates to 99:59. The stored digits are updated to the normalized value.
- `SEG_NORMALIZA_EN` undefined: digits pass unchanged; seconds tens up to 9 are allowed.

## Structure
- Package `entrada_pkg` holds:
  - FSM state enum.
  - `DIGITO_W`=4.
  - `MAX_DIGITOS`=4.
  - BCD constant 9 and seconds limit 6.
- Sub-module `normalizador_tempo` is a combinational MM:SS BCD normalizer, instantiated only under `SEG_NORMALIZA_EN`.
- Debounce counter width: $clog2(`DEBOUNCE`+1).

## Test plan
- Keys 1,2,3,0 each held 6 and released 6 cycles, `DEBOUNCE`=4 -> preset 12:30, `num_digitos`=4, exactly four `digito_ok` pulses.
- `tecla` high 2 cycles, then low -> digits unchanged, no `digito_ok`. Low glitch of 1 cycle in ESPERA -> no second acceptance.
- Fifth key 7 after 12:30 -> preset stays 12:30, no pulse. `bcd`=4'b1100 held 6 cycles -> no shift.
- `iniciar` with 0 digits -> no `carregar`.
- Enter 9,0 then `iniciar`:
  - Macro undefined -> `carregar` one cycle with 00:90.
  - Macro defined -> `carregar` with 01:30.
  - Entry 9,9,9,9 with macro defined -> 99:59.
- `limpar` after two digits -> 00:00, `num_digitos`=0. `reset` while in FILTRO -> all outputs 0, no `digito_ok`.
